// File: rtl/xor_cipher_pkg.sv
// Shared definitions for the XOR cipher controller: FSM states, default word size
// and the width helper for bit counters that must be able to hold MSG_SIZE itself.
package xor_cipher_pkg;

  localparam int MSG_SIZE_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_KEY  = 3'd1,
    S_RX   = 3'd2,
    S_ENC  = 3'd3,
    S_TX   = 3'd4,
    S_DONE = 3'd5
  } state_e;

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/xor_cipher_sipo.sv
// Serial-in parallel-out capture register: stores bit_i into data_o[count] LSB first
// whenever en_i is high, until MSG_SIZE bits have been taken.
module xor_cipher_sipo
  import xor_cipher_pkg::*;
#(
  parameter int MSG_SIZE = MSG_SIZE_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic                bit_i,
  output logic [MSG_SIZE-1:0] data_o,
  output logic                full_o
);

  localparam int CW = cnt_width(MSG_SIZE);
  localparam logic [CW-1:0] FULL_CNT = CW'(MSG_SIZE);

  logic [MSG_SIZE-1:0] data_q, data_d;
  logic [CW-1:0]       count_q, count_d;
  logic                take;

  assign take = en_i && (count_q != FULL_CNT);

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    if (clr_i) begin
      data_d  = '0;
      count_d = '0;
    end else if (take) begin
      data_d[count_q[CW-2:0]] = bit_i;
      count_d                 = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // Looks one edge ahead so the owner can leave its capture state on the last bit.
  assign full_o = (count_d == FULL_CNT);
  assign data_o = data_q;

endmodule

// File: rtl/xor_cipher_ctrl.sv
// Sequencer: loads a serial key, receives a serial message, XORs them and shifts the
// ciphertext out LSB first. Define XOR_CIPHER_CTRL_PARITY_EN to append a parity bit.
module xor_cipher_ctrl
  import xor_cipher_pkg::*;
#(
  parameter int MSG_SIZE = MSG_SIZE_DEF
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iKey_Load,
  input  logic iStart,
  input  logic iData_In,
  input  logic iData_Valid,
  output logic oBusy,
  output logic oKey_Ready,
  output logic oData,
  output logic oData_Valid,
  output logic oDone_flag
);

  localparam int CW = cnt_width(MSG_SIZE);
`ifdef XOR_CIPHER_CTRL_PARITY_EN
  localparam logic [CW-1:0] TX_LAST = CW'(MSG_SIZE);
`else
  localparam logic [CW-1:0] TX_LAST = CW'(MSG_SIZE - 1);
`endif

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [MSG_SIZE-1:0] cipher_q, cipher_d;
  logic [MSG_SIZE-1:0] key_w, msg_w;
  logic                key_ready_q, key_ready_d;
  logic                busy_q, busy_d;
  logic                data_q, data_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic                key_clr, key_en, key_full;
  logic                msg_clr, msg_en, msg_full;
  logic                tx_bit;

  // Valid/ready: iData_In is taken only on cycles with iData_Valid=1 while in KEY or
  // RX; oData is meaningful only while oData_Valid=1 and cannot be held off.
  assign key_clr = (state_q == S_IDLE) && iKey_Load;
  assign key_en  = (state_q == S_KEY) && iData_Valid;
  assign msg_clr = (state_q == S_IDLE) && !iKey_Load && iStart && key_ready_q;
  assign msg_en  = (state_q == S_RX) && iData_Valid;

  xor_cipher_sipo #(.MSG_SIZE(MSG_SIZE)) u_key_sipo (
    .clk_i  (iClk),
    .rst_i  (iRst),
    .clr_i  (key_clr),
    .en_i   (key_en),
    .bit_i  (iData_In),
    .data_o (key_w),
    .full_o (key_full)
  );

  xor_cipher_sipo #(.MSG_SIZE(MSG_SIZE)) u_msg_sipo (
    .clk_i  (iClk),
    .rst_i  (iRst),
    .clr_i  (msg_clr),
    .en_i   (msg_en),
    .bit_i  (iData_In),
    .data_o (msg_w),
    .full_o (msg_full)
  );

`ifdef XOR_CIPHER_CTRL_PARITY_EN
  assign tx_bit = (cnt_q == CW'(MSG_SIZE)) ? ^cipher_q : cipher_q[cnt_q[CW-2:0]];
`else
  assign tx_bit = cipher_q[cnt_q[CW-2:0]];
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cipher_q    <= '0;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cipher_q    <= cipher_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (iKey_Load)                  state_d = S_KEY;
        else if (iStart && key_ready_q) state_d = S_RX;
      end
      S_KEY:   if (key_full) state_d = S_IDLE;
      S_RX:    if (msg_full) state_d = S_ENC;
      S_ENC:   state_d = S_TX;
      S_TX:    if (cnt_q == TX_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    cipher_d    = cipher_q;
    key_ready_d = key_ready_q;
    data_d      = 1'b0;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    // Busy stays up through the done pulse so both fall on the same edge.
    busy_d      = (state_d != S_IDLE) || (state_q == S_DONE);
    case (state_q)
      S_IDLE: if (iKey_Load) key_ready_d = 1'b0;
      S_KEY:  if (key_full) key_ready_d = 1'b1;
      S_ENC: begin
        cipher_d = msg_w ^ key_w;
        cnt_d    = '0;
      end
      S_TX: begin
        data_d  = tx_bit;
        valid_d = 1'b1;
        cnt_d   = cnt_q + 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  assign oBusy       = busy_q;
  assign oKey_Ready  = key_ready_q;
  assign oData       = data_q;
  assign oData_Valid = valid_q;
  assign oDone_flag  = done_q;

endmodule
